mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 512x16 RAM between two requesters: port 0 = cpu, port 1 = aux
//   loader/DMA master. Sits between the requesters and the RAM instance in the top level.
//  Arbitrates one access per cycle using a round-robin pointer. Port 1 may request a
//   bounded lock for burst transfers.
//  Decodes the RAM window (addr[8]==0) and returns read data with fixed 1-cycle latency.
// PARAMETERS
//  ADDR_W      9   address width shared by both ports and the RAM
//  DATA_W      16  data width
//  SEL_BIT     8   address bit that selects RAM; 0 = RAM, 1 = unmapped
//  LOCK_MAX    8   max consecutive port-1 grants under lock before a forced release
// PORTS
//  clk          in   1       single clock; all state updates on posedge
//  reset        in   1       asynchronous, active-low; 0 clears all state immediately
//  p0_cmd       in   2       00 none, 01 read, 10 write, 11 reserved (treated as none)
//  p0_addr      in   ADDR_W  port-0 address
//  p0_wdata     in   DATA_W  port-0 write data
//  p0_ready     out  1       port-0 command accepted this cycle
//  p0_rvalid    out  1       port-0 read data valid (1 cycle after accepted read)
//  p0_rdata     out  DATA_W  port-0 read data
//  p1_cmd/p1_addr/p1_wdata/p1_ready/p1_rvalid/p1_rdata   same as port 0, for port 1
//  p1_lock      in   1       port 1 requests back-to-back grants
//  ram_addr     out  ADDR_W  to RAM read and write address
//  ram_write    out  1       RAM write enable
//  ram_din      out  DATA_W  RAM write data
//  ram_dout     in   DATA_W  RAM registered read data (valid 1 cycle after ram_addr)
//  unmapped     out  1       1-cycle pulse: an accepted access had addr[SEL_BIT]==1
// BEHAVIOUR
//  Reset (reset==0)
//   - rr_ptr=0 (port 0 favoured); lock_cnt=0; state=ARB.
//   - Read-pipeline registers cleared; no rvalid is issued for a read in flight.
//   - p*_rvalid=0, p*_rdata=0, unmapped=0.
//  Request handshake
//   - A requester holds cmd/addr/wdata stable until p*_ready==1.
//   - ready is combinational from the cmds and current state; at most one ready per cycle.
//  Arbitration
//   - Only one port active: it is granted.
//   - Both ports active in ARB: grant port rr_ptr, then rr_ptr <= ~granted port.
//  FSM states
//   - ARB: normal round-robin arbitration.
//   - LOCK1: entered when port 1 is granted with p1_lock==1. Port 1 has absolute priority.
//       lock_cnt increments per p1 grant.
//       Exit to ARB when p1_lock==0, or when p1_cmd==none, or when lock_cnt==LOCK_MAX.
//       On the forced exit, rr_ptr=0 so port 0 wins the next contention. lock_cnt clears on exit.
//  RAM drive
//   - ram_addr = granted addr; with no grant, ram_addr holds its last value.
//   - ram_din  = granted wdata.
//   - ram_write = granted cmd==10 && addr[SEL_BIT]==0.
//  Read return
//   - An accepted read registers {port, mapped}.
//   - Next cycle: that port's rvalid=1 and rdata=ram_dout when mapped, else 16'h0000.
//   - rdata holds its value until that port's next rvalid.
//  Unmapped accesses
//   - Writes are dropped (ram_write=0) but still acknowledged with ready.
//   - Reads return 0. Both kinds pulse unmapped in the cycle after acceptance.
//  Simultaneous events: a write accepted in cycle N followed by a read of the same address in N+1
//   returns the new data (RAM ordering); the arbiter adds no bypass.
// STRUCTURE
//  Shared pkg mem_pkg (constants shared with cpu):
//   - MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10.
//   - ARB state encoding.
//   - ADDR_W and DATA_W defaults.
//  Sub-module rr_pick2: 2-way round-robin picker (req[1:0], ptr -> gnt[1:0]).
//  Remaining logic stays flat: FSM, lock counter, read-return pipeline register.
// TESTING
//  Reset values: reset=0 -> all outputs 0; release with no cmds -> ready=0 on both ports, ram_write=0.
//  Single read
//   - Stimulus: write 16'hBEEF to 9'h010 via p0, then p0 read of 9'h010.
//   - Response: p0_ready in the same cycle; next cycle p0_rvalid=1, p0_rdata=16'hBEEF; p1 sees no rvalid.
//  Contention
//   - Stimulus: both ports hold reads for 4 cycles, starting with rr_ptr=0.
//   - Response: grant order p0,p1,p0,p1; each rvalid lands on the correct port.
//  Lock timeout
//   - Stimulus: p1_lock=1 with continuous p1 writes, p0 read pending.
//   - Response: exactly 8 p1 grants, then p0 granted.
//  Unmapped access
//   - Stimulus: p0 write to 9'h1FF, then read 9'h100.
//   - Response: ram_write stays 0; unmapped pulses twice; read returns 16'h0000 with rvalid=1.
//  Reset mid-read
//   - Stimulus: assert reset in the cycle after a p1 read is accepted.
//   - Response: p1_rvalid never rises for that read; FSM is in ARB and rr_ptr=0 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: memory command codes, arbiter state encoding and default widths shared with the cpu
package mem_pkg;
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 16;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_READ = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} arb_state_t;
  function automatic logic cmd_active(input logic [1:0] cmd);
    return cmd == MEM_READ || cmd == MEM_WRITE;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: 2-way round-robin picker, ptr selects the winner when both request
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb gnt = &req ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter with port-1 burst lock in front of a 1-cycle-latency RAM
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int SEL_BIT = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        p0_cmd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic [1:0]        p1_cmd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p1_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              unmapped
);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  arb_state_t state;
  logic rr_ptr, hold, locking, mapped, any_gnt;
  logic rd_v, rd_port, rd_mapped;
  logic [LCW-1:0] lock_cnt, cnt_nxt;
  logic [1:0] req, pick, gnt, g_cmd;
  logic [ADDR_W-1:0] g_addr, last_addr;
  logic [DATA_W-1:0] g_wdata, rd_data, p0_hold, p1_hold;
  rr_pick2 u_pick (.req(req), .ptr(rr_ptr), .gnt(pick));
  always_comb begin
    req = {cmd_active(p1_cmd), cmd_active(p0_cmd)};
    hold = state == LOCK1 && p1_lock && req[1];
    gnt = hold ? 2'b10 : pick;
    any_gnt = |gnt;
    g_cmd = gnt[1] ? p1_cmd : p0_cmd;
    g_addr = gnt[1] ? p1_addr : p0_addr;
    g_wdata = gnt[1] ? p1_wdata : p0_wdata;
    mapped = !g_addr[SEL_BIT];
    locking = gnt[1] && p1_lock;
    cnt_nxt = lock_cnt + 1'b1;
    p0_ready = gnt[0];
    p1_ready = gnt[1];
    ram_addr = any_gnt ? g_addr : last_addr;
    ram_din = g_wdata;
    ram_write = any_gnt && g_cmd == MEM_WRITE && mapped;
    rd_data = rd_mapped ? ram_dout : '0;
    p0_rvalid = rd_v && !rd_port;
    p1_rvalid = rd_v && rd_port;
    p0_rdata = p0_rvalid ? rd_data : p0_hold;
    p1_rdata = p1_rvalid ? rd_data : p1_hold;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
      rr_ptr <= 1'b0;
      lock_cnt <= '0;
    end else begin
      if (!hold && &req) rr_ptr <= gnt[0];
      if (locking && cnt_nxt != LCW'(LOCK_MAX)) begin
        state <= LOCK1;
        lock_cnt <= cnt_nxt;
      end else begin
        state <= ARB;
        lock_cnt <= '0;
        if (locking) rr_ptr <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v <= 1'b0;
      rd_port <= 1'b0;
      rd_mapped <= 1'b0;
      unmapped <= 1'b0;
      last_addr <= '0;
      p0_hold <= '0;
      p1_hold <= '0;
    end else begin
      rd_v <= any_gnt && g_cmd == MEM_READ;
      rd_port <= gnt[1];
      rd_mapped <= mapped;
      unmapped <= any_gnt && !mapped;
      if (any_gnt) last_addr <= g_addr;
      if (p0_rvalid) p0_hold <= p0_rdata;
      if (p1_rvalid) p1_hold <= p1_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter/RAM model
module tb_mem_arbiter;
  localparam int LOCK_MAX = 8;
  logic clk = 1'b0, reset;
  logic [1:0] p0_cmd, p1_cmd;
  logic [8:0] p0_addr, p1_addr, ram_addr;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_din, ram_dout;
  logic p0_ready, p1_ready, p0_rvalid, p1_rvalid, p1_lock, ram_write, unmapped;
  logic [15:0] ram [512] = '{default: 16'h0};
  logic [15:0] ref_mem [512] = '{default: 16'h0};
  int n_chk = 0, n_fail = 0;
  int g, fav, lock_n;
  bit locked, e_unm, obs_wr, obs_unm;
  bit [1:0] e_rv;
  logic [1:0] obs_rdy;
  logic [8:0] m_last;
  logic [15:0] e_rd [2];
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout), .unmapped(unmapped)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_write) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    locked = 0;
    lock_n = 0;
    fav = 0;
    m_last = '0;
    e_rv = '0;
    e_rd[0] = '0;
    e_rd[1] = '0;
    e_unm = 0;
  endtask
  task automatic step(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] w0,
                      input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] w1,
                      input logic lk, input bit kill);
    bit act0, act1, hold;
    logic [1:0] cg;
    logic [8:0] ag;
    logic [15:0] wg;
    p0_cmd = c0; p0_addr = a0; p0_wdata = w0;
    p1_cmd = c1; p1_addr = a1; p1_wdata = w1; p1_lock = lk;
    #1;
    act0 = c0 == 2'd1 || c0 == 2'd2;
    act1 = c1 == 2'd1 || c1 == 2'd2;
    hold = locked && lk && act1;
    g = hold ? 1 : (act0 && act1) ? fav : act0 ? 0 : act1 ? 1 : -1;
    cg = g == 1 ? c1 : c0;
    ag = g == 1 ? a1 : a0;
    wg = g == 1 ? w1 : w0;
    obs_rdy = {p1_ready, p0_ready};
    obs_wr = ram_write;
    chk("p0_ready", p0_ready, g == 0);
    chk("p1_ready", p1_ready, g == 1);
    chk("ram_write", ram_write, g >= 0 && cg == 2'd2 && !ag[8]);
    chk("ram_addr", ram_addr, g >= 0 ? ag : m_last);
    if (g >= 0 && cg == 2'd2) chk("ram_din", ram_din, wg);
    if (!hold && act0 && act1) fav = 1 - g;
    if (g == 1 && lk) begin
      lock_n++;
      locked = 1;
      if (lock_n == LOCK_MAX) begin
        locked = 0;
        lock_n = 0;
        fav = 0;
      end
    end else begin
      locked = 0;
      lock_n = 0;
    end
    e_rv = '0;
    e_unm = g >= 0 && ag[8];
    if (g >= 0) begin
      m_last = ag;
      if (cg == 2'd1) begin
        e_rv[g] = 1'b1;
        e_rd[g] = ag[8] ? 16'h0 : ref_mem[ag];
      end
      if (cg == 2'd2 && !ag[8]) ref_mem[ag] = wg;
    end
    @(posedge clk);
    if (kill) begin
      reset = 1'b0;
      mreset();
    end
    #1;
    obs_unm = unmapped;
    chk("p0_rvalid", p0_rvalid, e_rv[0]);
    chk("p1_rvalid", p1_rvalid, e_rv[1]);
    chk("p0_rdata", p0_rdata, e_rd[0]);
    chk("p1_rdata", p1_rdata, e_rd[1]);
    chk("unmapped", unmapped, e_unm);
  endtask
  initial begin
    int n, unm;
    bit b0, b1;
    logic [1:0] c0, c1;
    logic [8:0] a0, a1;
    logic [15:0] w0, w1;
    reset = 1'b0;
    p0_cmd = 2'd0; p0_addr = '0; p0_wdata = '0;
    p1_cmd = 2'd0; p1_addr = '0; p1_wdata = '0; p1_lock = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_unmapped", unmapped, 0);
    chk("rst_ready", {p1_ready, p0_ready}, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    #2 reset = 1'b1;
    step(2'd0, 9'h0, 16'h0, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    step(2'd2, 9'h010, 16'hBEEF, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    step(2'd1, 9'h010, 16'h0, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    chk("single_rvalid", p0_rvalid, 1);
    chk("single_rdata", p0_rdata, 16'hBEEF);
    chk("single_p1_rvalid", p1_rvalid, 0);
    for (int k = 0; k < 4; k++) begin
      step(2'd1, 9'h010, 16'h0, 2'd1, 9'h020, 16'h0, 1'b0, 1'b0);
      chk("contention_grant", obs_rdy, k % 2 ? 2'b10 : 2'b01);
    end
    step(2'd0, 9'h0, 16'h0, 2'd2, 9'h030, 16'h1111, 1'b1, 1'b0);
    n = obs_rdy == 2'b10;
    for (int i = 0; i < 20; i++) begin
      step(2'd1, 9'h040, 16'h0, 2'd2, 9'h031 + 9'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
      if (obs_rdy == 2'b01) break;
      n += obs_rdy == 2'b10;
    end
    chk("lock_grants", n, LOCK_MAX);
    chk("lock_release_p0", obs_rdy, 2'b01);
    step(2'd0, 9'h0, 16'h0, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    unm = 0;
    step(2'd2, 9'h1FF, 16'hDEAD, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    chk("unm_write_dropped", obs_wr, 0);
    unm += obs_unm;
    step(2'd1, 9'h100, 16'h0, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    chk("unm_read_wr", obs_wr, 0);
    unm += obs_unm;
    chk("unm_rvalid", p0_rvalid, 1);
    chk("unm_rdata", p0_rdata, 16'h0);
    step(2'd0, 9'h0, 16'h0, 2'd0, 9'h0, 16'h0, 1'b0, 1'b0);
    unm += obs_unm;
    chk("unm_pulses", unm, 2);
    step(2'd1, 9'h050, 16'h0, 2'd1, 9'h010, 16'h0, 1'b0, 1'b0);
    step(2'd0, 9'h0, 16'h0, 2'd1, 9'h010, 16'h0, 1'b0, 1'b1);
    chk("midrst_rvalid", p1_rvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_rvalid_late", p1_rvalid, 0);
    #2 reset = 1'b1;
    step(2'd1, 9'h050, 16'h0, 2'd1, 9'h010, 16'h0, 1'b0, 1'b0);
    chk("post_rst_grant", obs_rdy, 2'b01);
    b0 = 0;
    b1 = 0;
    c0 = '0; c1 = '0; a0 = '0; a1 = '0; w0 = '0; w1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!b0) begin
        c0 = 2'($urandom_range(0, 3));
        a0 = {($urandom_range(0, 7) == 0), 4'h0, 4'($urandom)};
        w0 = 16'($urandom);
        b0 = c0 == 2'd1 || c0 == 2'd2;
      end
      if (!b1) begin
        c1 = 2'($urandom_range(0, 3));
        a1 = {($urandom_range(0, 7) == 0), 4'h0, 4'($urandom)};
        w1 = 16'($urandom);
        b1 = c1 == 2'd1 || c1 == 2'd2;
      end
      step(c0, a0, w0, c1, a1, w1, $urandom_range(0, 9) != 0, 1'b0);
      if (g == 0) b0 = 0;
      if (g == 1) b1 = 0;
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
